// File: rtl/conv_window_scheduler_pkg.sv
// Shared definitions for the convolution window scheduler: one-hot state
// encoding, datapath pipeline depth and LeNet-5 conv layer geometries.
package conv_window_scheduler_pkg;

  // One-hot layer sequencing states.
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LOAD_W = 5'b00010,
    S_CALC   = 5'b00100,
    S_DRAIN  = 5'b01000,
    S_DONE   = 5'b10000
  } state_t;

  // Multiply stage plus a five-level adder tree over 25 products.
  localparam int PIPE_LATENCY_DEFAULT = 6;

  // conv1: 32x32 input, 5x5 kernel, six 28x28 maps, 25 taps + bias per map.
  localparam int CONV1_INPUT_WIDTH        = 32;
  localparam int CONV1_OUTPUT_WIDTH       = 28;
  localparam int CONV1_OUTPUT_HEIGTH      = 28;
  localparam int CONV1_OUTPUT_FEATURE_MAP = 6;
  localparam int CONV1_W_DEPTH            = 26;

  // conv2: 14x14 pooled input, 5x5 kernel, sixteen 10x10 maps.
  localparam int CONV2_INPUT_WIDTH        = 14;
  localparam int CONV2_OUTPUT_WIDTH       = 10;
  localparam int CONV2_OUTPUT_HEIGTH      = 10;
  localparam int CONV2_OUTPUT_FEATURE_MAP = 16;
  localparam int CONV2_W_DEPTH            = 26;

endpackage

// File: rtl/conv_result_tag_pipe.sv
// Delay line carrying {valid, addr, map} alongside the datapath so every
// result leaves tagged with the output position and map it belongs to.
module conv_result_tag_pipe #(
  parameter int DEPTH  = 6,
  parameter int ADDR_W = 10,
  parameter int MAP_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [MAP_W-1:0]  in_map,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [MAP_W-1:0]  out_map
);

  logic              valid_q [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [MAP_W-1:0]  map_q   [DEPTH];

  // Shift every cycle; the datapath has no stall, so neither does its tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this array is flops, not RAM, and is cleared on reset so that
      // windows in flight when the layer is aborted never surface as results.
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        map_q[i]   <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      map_q[0]   <= in_map;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
        map_q[i]   <= map_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign out_map   = map_q[DEPTH-1];

endmodule

// File: rtl/conv_window_scheduler.sv
// Layer sequencer for the 25-tap conv datapath: per output map it loads
// weights and bias, raster-scans one 5x5 window per cycle, drains the
// pipeline, and tags each result with its output address and map.
module conv_window_scheduler
  import conv_window_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH         = 12,
  parameter int INPUT_WIDTH        = CONV1_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH       = CONV1_OUTPUT_WIDTH,
  parameter int OUTPUT_HEIGTH      = CONV1_OUTPUT_HEIGTH,
  parameter int OUTPUT_FEATURE_MAP = CONV1_OUTPUT_FEATURE_MAP,
  parameter int W_DEPTH            = CONV1_W_DEPTH,
  parameter int PIPE_LATENCY       = PIPE_LATENCY_DEFAULT
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic                                           hold,
  output logic                                           w_rd_en,
  output logic [$clog2(W_DEPTH*OUTPUT_FEATURE_MAP)-1:0]  w_rd_addr,
  output logic                                           wreg_we,
  output logic [$clog2(W_DEPTH)-1:0]                     wreg_idx,
  output logic                                           win_valid,
  output logic [$clog2(INPUT_WIDTH*INPUT_WIDTH)-1:0]     win_base,
  output logic                                           out_valid,
  output logic [$clog2(OUTPUT_WIDTH*OUTPUT_HEIGTH)-1:0]  out_addr,
  output logic [$clog2(OUTPUT_FEATURE_MAP)-1:0]          out_map,
  output logic                                           busy,
  output logic                                           done
);

  localparam int WA_W  = $clog2(W_DEPTH*OUTPUT_FEATURE_MAP);
  localparam int WI_W  = $clog2(W_DEPTH);
  localparam int WB_W  = $clog2(INPUT_WIDTH*INPUT_WIDTH);
  localparam int OA_W  = $clog2(OUTPUT_WIDTH*OUTPUT_HEIGTH);
  localparam int OM_W  = $clog2(OUTPUT_FEATURE_MAP);
  localparam int K_W   = $clog2(W_DEPTH+1);
  localparam int ROW_W = $clog2(OUTPUT_HEIGTH);
  localparam int COL_W = $clog2(OUTPUT_WIDTH);
  localparam int DR_W  = $clog2(PIPE_LATENCY);

  localparam logic [K_W-1:0]   K_LAST   = K_W'(W_DEPTH);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUTPUT_HEIGTH-1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUTPUT_WIDTH-1);
  localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(PIPE_LATENCY-1);
  localparam logic [OM_W-1:0]  MAP_LAST = OM_W'(OUTPUT_FEATURE_MAP-1);

  state_t           state;
  state_t           state_next;
  logic [OM_W-1:0]  map;
  logic [K_W-1:0]   k;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [DR_W-1:0]  drain_cnt;

  logic             last_window;
  logic [OA_W-1:0]  tag_addr;
  logic [OM_W-1:0]  tag_map;

  assign last_window = (row == ROW_LAST) && (col == COL_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode; start only matters in IDLE, hold only in CALC.
  always_comb begin
    // NOTE: defaulting to the current state up front keeps this block free
    // of inferred latches on paths that do not assign it.
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_LOAD_W;
      S_LOAD_W: if (k == K_LAST) state_next = S_CALC;
      S_CALC:   if (!hold && last_window) state_next = S_DRAIN;
      S_DRAIN:  if (drain_cnt == DR_LAST)
                  state_next = (map == MAP_LAST) ? S_DONE : S_LOAD_W;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode: weight fetch/write strobes, window issue, status.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    wreg_we   = 1'b0;
    wreg_idx  = '0;
    win_valid = 1'b0;
    win_base  = '0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    unique case (state)
      S_LOAD_W: begin
        // Reads run k=0..W_DEPTH-1; writes trail by one for the memory latency.
        if (k != K_LAST) begin
          w_rd_en   = 1'b1;
          w_rd_addr = WA_W'(map) * WA_W'(W_DEPTH) + WA_W'(k);
        end
        if (k != '0) begin
          wreg_we  = 1'b1;
          wreg_idx = WI_W'(k - K_W'(1));
        end
      end
      S_CALC: begin
        if (!hold) begin
          win_valid = 1'b1;
          win_base  = WB_W'(row) * WB_W'(INPUT_WIDTH) + WB_W'(col);
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Map, weight-index, raster and drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      map       <= '0;
      k         <= '0;
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        S_LOAD_W: begin
          k   <= (k == K_LAST) ? '0 : k + K_W'(1);
          row <= '0;
          col <= '0;
        end
        S_CALC: begin
          if (!hold) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DR_LAST) begin
            drain_cnt <= '0;
            if (map != MAP_LAST) map <= map + OM_W'(1);
          end else begin
            drain_cnt <= drain_cnt + DR_W'(1);
          end
        end
        default: begin
          map       <= '0;
          k         <= '0;
          row       <= '0;
          col       <= '0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // Tags are zeroed when no window issues so idle slots carry no stale address.
  assign tag_addr = win_valid ? OA_W'(row) * OA_W'(OUTPUT_WIDTH) + OA_W'(col) : '0;
  assign tag_map  = win_valid ? map : '0;

  generate
    if (DATA_WIDTH > 0) begin : g_tag
      conv_result_tag_pipe #(
        .DEPTH  (PIPE_LATENCY),
        .ADDR_W (OA_W),
        .MAP_W  (OM_W)
      ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (win_valid),
        .in_addr   (tag_addr),
        .in_map    (tag_map),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_map   (out_map)
      );
    end else begin : g_no_tag
      // Without a datapath word there is no result to tag.
      assign out_valid = 1'b0;
      assign out_addr  = '0;
      assign out_map   = '0;
    end
  endgenerate

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: a schedule model builds the expected
// per-cycle outputs from the layer rules (load, scan with stalls, drain,
// done); the DUT is compared against it every cycle, plus landmark checks.
`timescale 1ns/1ps
module tb_conv_window_scheduler;

  localparam int IW   = 32;
  localparam int OW   = 28;
  localparam int OH   = 28;
  localparam int FM   = 6;
  localparam int WD   = 26;
  localparam int LAT  = 6;
  localparam int POS  = OW * OH;
  localparam int MAXC = 8000;
  localparam int MAP_T = WD + 1 + POS + LAT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       w_rd_en;
  logic [7:0] w_rd_addr;
  logic       wreg_we;
  logic [4:0] wreg_idx;
  logic       win_valid;
  logic [9:0] win_base;
  logic       out_valid;
  logic [9:0] out_addr;
  logic [2:0] out_map;
  logic       busy;
  logic       done;

  conv_window_scheduler #(
    .DATA_WIDTH(12), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .OUTPUT_HEIGTH(OH),
    .OUTPUT_FEATURE_MAP(FM), .W_DEPTH(WD), .PIPE_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .wreg_we(wreg_we), .wreg_idx(wreg_idx),
    .win_valid(win_valid), .win_base(win_base), .out_valid(out_valid),
    .out_addr(out_addr), .out_map(out_map), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       we;
    logic [4:0] idx;
    logic       win;
    logic [9:0] base;
    logic       ov;
    logic [9:0] oaddr;
    logic [2:0] omap;
  } obs_t;

  obs_t exp_q     [MAXC];
  bit   hold_arr  [MAXC];
  bit   start_arr [MAXC];

  int n_cmp = 0;
  int n_err = 0;

  int first_rd, first_we, first_win, done_cyc, busy_cnt, last_base, out_cnt;
  int rd26_cyc, out783_m0_cyc, m1_first_we;

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      hold_arr[i]  = 1'b0;
      start_arr[i] = 1'b0;
    end
  endtask

  // Expected schedule: per map, W_DEPTH+1 load cycles, one window per
  // non-held cycle in raster order, LAT drain cycles; then one done cycle.
  task automatic build_model(input int rst_cycle, output int end_cyc);
    int t;
    for (int i = 0; i < MAXC; i++) exp_q[i] = '0;
    t = 1;
    for (int m = 0; m < FM; m++) begin
      for (int k = 0; k <= WD; k++) begin
        exp_q[t].busy = 1'b1;
        if (k < WD) begin
          exp_q[t].rd_en   = 1'b1;
          exp_q[t].rd_addr = 8'(m * WD + k);
        end
        if (k >= 1) begin
          exp_q[t].we  = 1'b1;
          exp_q[t].idx = 5'(k - 1);
        end
        t++;
      end
      for (int p = 0; p < POS; p++) begin
        while (hold_arr[t] && t < MAXC - 2 * LAT) begin
          exp_q[t].busy = 1'b1;
          t++;
        end
        exp_q[t].busy = 1'b1;
        exp_q[t].win  = 1'b1;
        exp_q[t].base = 10'((p / OW) * IW + (p % OW));
        exp_q[t + LAT].ov    = 1'b1;
        exp_q[t + LAT].oaddr = 10'(p);
        exp_q[t + LAT].omap  = 3'(m);
        t++;
      end
      for (int d = 0; d < LAT; d++) begin
        exp_q[t].busy = 1'b1;
        t++;
      end
    end
    exp_q[t].busy = 1'b1;
    exp_q[t].done = 1'b1;
    end_cyc = t;
    if (rst_cycle >= 0)
      for (int i = rst_cycle + 1; i < MAXC; i++) exp_q[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive cycles 0..last (cycle 0 = first cycle after the call) and compare
  // every cycle against the model; stops after 10 failures in one run.
  task automatic run_cycles(input string name, input int last, input int rst_cycle);
    obs_t got;
    int   errs;
    errs = 0;
    first_rd = -1; first_we = -1; first_win = -1; done_cyc = -1;
    busy_cnt = 0; last_base = -1; out_cnt = 0;
    rd26_cyc = -1; out783_m0_cyc = -1; m1_first_we = -1;
    for (int c = 0; c <= last; c++) begin
      start = start_arr[c];
      hold  = hold_arr[c];
      rst   = (c == rst_cycle);
      @(negedge clk);
      got = {busy, done, w_rd_en, w_rd_addr, wreg_we, wreg_idx,
             win_valid, win_base, out_valid, out_addr, out_map};
      if (got.rd_en && first_rd < 0) first_rd = c;
      if (got.we && first_we < 0) first_we = c;
      if (got.win && first_win < 0) first_win = c;
      if (got.done) done_cyc = c;
      if (got.busy) busy_cnt++;
      if (got.win) last_base = int'(got.base);
      if (got.ov) out_cnt++;
      if (got.rd_en && got.rd_addr == 8'd26 && rd26_cyc < 0) rd26_cyc = c;
      if (got.ov && got.oaddr == 10'd783 && got.omap == 3'd0) out783_m0_cyc = c;
      if (got.we && rd26_cyc >= 0 && c > rd26_cyc && m1_first_we < 0) m1_first_we = c;
      n_cmp++;
      if (got !== exp_q[c]) begin
        n_err++;
        errs++;
        $display("FAIL %s cyc %0d: got busy=%b done=%b rd=%b/%0d we=%b/%0d win=%b/%0d out=%b/%0d/%0d; expected busy=%b done=%b rd=%b/%0d we=%b/%0d win=%b/%0d out=%b/%0d/%0d",
                 name, c, got.busy, got.done, got.rd_en, got.rd_addr, got.we, got.idx,
                 got.win, got.base, got.ov, got.oaddr, got.omap,
                 exp_q[c].busy, exp_q[c].done, exp_q[c].rd_en, exp_q[c].rd_addr,
                 exp_q[c].we, exp_q[c].idx, exp_q[c].win, exp_q[c].base,
                 exp_q[c].ov, exp_q[c].oaddr, exp_q[c].omap);
      end
      @(posedge clk);
      #1;
      if (errs >= 10) break;
    end
    start = 1'b0; hold = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1; start = 1'b1; hold = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    got = {busy, done, w_rd_en, w_rd_addr, wreg_we, wreg_idx,
           win_valid, win_base, out_valid, out_addr, out_map};
    n_cmp++;
    if (got !== obs_t'('0)) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, expected 0", got);
    end
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    got = {busy, done, w_rd_en, w_rd_addr, wreg_we, wreg_idx,
           win_valid, win_base, out_valid, out_addr, out_map};
    n_cmp++;
    if (got !== obs_t'('0)) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h, expected 0", got);
    end
  endtask

  task automatic test_nominal();
    int end_c;
    do_reset();
    clear_stim();
    start_arr[0] = 1'b1;
    build_model(-1, end_c);
    run_cycles("nominal", end_c + 8, -1);
    n_cmp += 9;
    if (first_rd != 1)   begin n_err++; $display("FAIL first_rd_cycle: got %0d, expected 1", first_rd); end
    if (first_we != 2)   begin n_err++; $display("FAIL first_we_cycle: got %0d, expected 2", first_we); end
    if (first_win != 28) begin n_err++; $display("FAIL first_win_cycle: got %0d, expected 28", first_win); end
    if (done_cyc != 4903) begin n_err++; $display("FAIL done_cycle: got %0d, expected 4903", done_cyc); end
    if (busy_cnt != 4903) begin n_err++; $display("FAIL busy_cycles: got %0d, expected 4903", busy_cnt); end
    if (last_base != 891) begin n_err++; $display("FAIL last_win_base: got %0d, expected 891", last_base); end
    if (out_cnt != FM * POS) begin n_err++; $display("FAIL out_valid_count: got %0d, expected %0d", out_cnt, FM * POS); end
    if (rd26_cyc != MAP_T + 1) begin n_err++; $display("FAIL map1_first_rd: got %0d, expected %0d", rd26_cyc, MAP_T + 1); end
    if (!(out783_m0_cyc >= 0 && m1_first_we > out783_m0_cyc)) begin
      n_err++;
      $display("FAIL map_transition_order: got out783 at %0d and map1 we at %0d, expected out783 first", out783_m0_cyc, m1_first_we);
    end
  endtask

  task automatic test_hold_mid_row();
    int end_c;
    do_reset();
    clear_stim();
    start_arr[0] = 1'b1;
    for (int t = 41; t <= 50; t++) hold_arr[t] = 1'b1;
    build_model(-1, end_c);
    run_cycles("hold_mid_row", end_c + 8, -1);
    n_cmp += 2;
    if (rd26_cyc != 828) begin n_err++; $display("FAIL hold_map_time: got map1 start %0d, expected 828", rd26_cyc); end
    if (done_cyc != 4913) begin n_err++; $display("FAIL hold_done_cycle: got %0d, expected 4913", done_cyc); end
  endtask

  task automatic test_ignored_inputs();
    int end_c;
    int base;
    do_reset();
    clear_stim();
    start_arr[0] = 1'b1;
    for (int m = 0; m < FM; m++) begin
      base = 1 + m * MAP_T;
      for (int t = base; t <= base + WD; t++) hold_arr[t] = 1'b1;
      for (int t = base + MAP_T - LAT; t < base + MAP_T; t++) hold_arr[t] = 1'b1;
    end
    for (int i = 0; i < 40; i++) start_arr[$urandom_range(1, 4903)] = 1'b1;
    start_arr[1] = 1'b1;
    start_arr[4903] = 1'b1;
    build_model(-1, end_c);
    run_cycles("ignored_inputs", end_c + 8, -1);
    n_cmp += 2;
    if (done_cyc != 4903) begin n_err++; $display("FAIL ignored_done_cycle: got %0d, expected 4903", done_cyc); end
    if (busy_cnt != 4903) begin n_err++; $display("FAIL ignored_busy_cycles: got %0d, expected 4903", busy_cnt); end
  endtask

  task automatic test_random_hold();
    int end_c;
    do_reset();
    clear_stim();
    start_arr[0] = 1'b1;
    for (int t = 1; t < MAXC; t++) hold_arr[t] = ($urandom_range(0, 7) == 0);
    build_model(-1, end_c);
    for (int i = 0; i < 30; i++) start_arr[$urandom_range(1, end_c)] = 1'b1;
    run_cycles("random_hold", end_c + 8, -1);
    n_cmp += 2;
    if (done_cyc != end_c) begin n_err++; $display("FAIL random_done_cycle: got %0d, expected %0d", done_cyc, end_c); end
    if (out_cnt != FM * POS) begin n_err++; $display("FAIL random_out_count: got %0d, expected %0d", out_cnt, FM * POS); end
  endtask

  task automatic test_reset_mid_calc();
    int end_c;
    do_reset();
    clear_stim();
    start_arr[0] = 1'b1;
    build_model(131, end_c);
    run_cycles("reset_mid_calc", 145, 131);
    n_cmp++;
    if (done_cyc != -1) begin n_err++; $display("FAIL abort_done: got done at %0d, expected none", done_cyc); end
    // Fresh start straight after the abort, with no further reset.
    clear_stim();
    start_arr[0] = 1'b1;
    build_model(-1, end_c);
    run_cycles("replay", end_c + 8, -1);
    n_cmp += 2;
    if (first_win != 28) begin n_err++; $display("FAIL replay_first_win: got %0d, expected 28", first_win); end
    if (done_cyc != 4903) begin n_err++; $display("FAIL replay_done_cycle: got %0d, expected 4903", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hold_mid_row();
    test_ignored_inputs();
    test_random_hold();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequences one convolution layer through the 25-tap multiply/adder-tree datapath: per output feature map it fetches the 25 weights plus bias into the datapath's weight registers, then raster-scans every output position, issuing one 5x5 window per cycle. It tracks the fixed pipeline latency of the datapath so each result leaves with its output address and map index. It sits between the layer-level control (start/done) and the input buffer, weight memory and output buffer of a LeNet-5 conv stage.

## Interface
- DATA_WIDTH, 12, datapath word width (informational; no data passes through this block)
- INPUT_WIDTH, 32, input feature-map row length
- OUTPUT_WIDTH, 28, output columns per row
- OUTPUT_HEIGTH, 28, output rows
- OUTPUT_FEATURE_MAP, 6, number of output maps
- W_DEPTH, 26, weight words per map (25 taps + bias)
- PIPE_LATENCY, 6, datapath latency: 1 multiply stage + 5 adder stages
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a layer; sampled only in IDLE
- hold  in  1  suppresses window issue in CALC; ignored in other states
- w_rd_en  out  1  weight memory read strobe
- w_rd_addr  out  $clog2(W_DEPTH*OUTPUT_FEATURE_MAP)  weight address = map*W_DEPTH + k
- wreg_we  out  1  write strobe for datapath weight/bias registers
- wreg_idx  out  $clog2(W_DEPTH)  0..24 = tap, 25 = bias
- win_valid  out  1  window issued to the datapath this cycle
- win_base  out  $clog2(INPUT_WIDTH*INPUT_WIDTH)  top-left input address = row*INPUT_WIDTH + col
- out_valid  out  1  datapath output is a valid result
- out_addr  out  $clog2(OUTPUT_WIDTH*OUTPUT_HEIGTH)  row*OUTPUT_WIDTH + col of that result
- out_map  out  $clog2(OUTPUT_FEATURE_MAP)  map of that result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at layer end

## Operation
- States: IDLE, LOAD_W, CALC, DRAIN, DONE (one-hot).
- IDLE: start=1 -> LOAD_W with map=0, k=0. start in any other state is ignored.
- LOAD_W lasts W_DEPTH+1 cycles, k = 0..W_DEPTH. Cycle k<W_DEPTH: w_rd_en=1, w_rd_addr=map*W_DEPTH+k. Cycle k>=1: wreg_we=1, wreg_idx=k-1 (weight memory has 1-cycle read latency). After k=W_DEPTH -> CALC with row=col=0.
- CALC: each cycle with hold=0 asserts win_valid with current (row,col), then advances col; col wraps at OUTPUT_WIDTH-1 to 0 with row+1. hold=1: win_valid=0, counters frozen. Issuing (OUTPUT_HEIGTH-1, OUTPUT_WIDTH-1) -> DRAIN.
- DRAIN: PIPE_LATENCY cycles, no issue, so weights are not rewritten under in-flight windows. Then map<OUTPUT_FEATURE_MAP-1 -> map+1, LOAD_W; else -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Result tracking: PIPE_LATENCY-deep shift register of {valid, addr, map}, loaded from win_valid/(row*OUTPUT_WIDTH+col)/map; the tail drives out_valid/out_addr/out_map. It shifts every cycle regardless of hold, since the datapath has no enable.
- Address arithmetic unsigned, exact widths; no overflow possible at defaults (max win_base 27*32+27=891, max out_addr 783).

## Timing
- Reset: state=IDLE; all outputs 0; counters 0; tracking shift register cleared. rst mid-operation aborts the layer; in-flight results are discarded (out_valid stays 0) and done is not pulsed.
- start at cycle 0 -> first w_rd_en at cycle 1; first wreg_we at cycle 2; first win_valid at cycle 28 (hold=0).
- out_valid for a window issued at cycle t appears at cycle t+PIPE_LATENCY.
- Per map without hold: 27 + 784 + 6 = 817 cycles; layer busy = 6*817 + 1 (DONE) = 4903 cycles.
- Last out_valid of a map occurs in the final DRAIN cycle, before the next map's first wreg_we.

## Structure
- Shared package: state encoding, PIPE_LATENCY, and layer geometry constants for conv1 and conv2 (OUTPUT_WIDTH/HEIGTH/FEATURE_MAP, W_DEPTH).
- One sub-module: conv_result_tag_pipe, the parameterized {valid, addr, map} delay line.

## Test plan
- Reset then start, hold=0 -> w_rd_addr 0..25 at cycles 1..26, wreg_idx 0..25 at cycles 2..27, win_base 0 at cycle 28, done pulse at cycle 4903.
- Scan order -> win_base sequence 0,1,...,27,32,33,... and last window 891; out_addr 0..783 in order, each 6 cycles after its issue, out_map constant per map.
- hold high for 10 cycles mid-row at col=13 -> no win_valid for those 10 cycles, resumes at col=13 with no gap or duplicate in out_addr; map time 827.
- Map transition -> second map w_rd_addr 26..51, no wreg_we before the out_valid with out_addr=783, out_map=0.
- rst asserted 3 cycles after a window issue in CALC -> all outputs 0 the next cycle, no out_valid afterward; a fresh start replays from map 0.
- start pulsed while busy, and hold asserted in LOAD_W/DRAIN -> no effect; cycle counts unchanged.
